// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: register index width, opcode/funct codes,
// ALU operation encodings and the decoded-control bundle.
package mips_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALU_W   = 4;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SUBU = 4'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;

  // Decoded control for one instruction
  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             alu_src_imm;
    logic             reg_wr_en;
    logic             mem_rd;
    logic             mem_wr;
    logic             branch;
    logic             illegal;
    logic             uses_rt;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
  } ctrl_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder: control bits, immediate, destination
// register and whether the rt field is read as a source.
module decode_ctrl
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl_c
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [REG_W-1:0] rt_f;
  logic [REG_W-1:0] rd_f;
  logic [15:0]      imm16;
  logic             unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign rt_f        = instr[20:16];
  assign rd_f        = instr[15:11];
  assign imm16       = instr[15:0];
  // rs is consumed by the stage, shamt by nobody
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  // Opcode/funct decode; an unknown encoding yields only the illegal flag
  always_comb begin
    ctrl_c = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_c.uses_rt   = 1'b1;
        ctrl_c.reg_wr_en = 1'b1;
        ctrl_c.rd        = rd_f;
        case (funct)
          FN_ADD:  ctrl_c.alu_op = ALU_ADD;
          FN_SUB:  ctrl_c.alu_op = ALU_SUB;
          FN_SUBU: ctrl_c.alu_op = ALU_SUBU;
          FN_AND:  ctrl_c.alu_op = ALU_AND;
          FN_OR:   ctrl_c.alu_op = ALU_OR;
          FN_SLT:  ctrl_c.alu_op = ALU_SLT;
          default: begin
            ctrl_c         = '0;
            ctrl_c.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_c.alu_op      = ALU_ADD;
        ctrl_c.alu_src_imm = 1'b1;
        ctrl_c.reg_wr_en   = 1'b1;
        ctrl_c.rd          = rt_f;
        ctrl_c.imm         = sext16(imm16);
      end
      OP_ANDI: begin
        ctrl_c.alu_op      = ALU_AND;
        ctrl_c.alu_src_imm = 1'b1;
        ctrl_c.reg_wr_en   = 1'b1;
        ctrl_c.rd          = rt_f;
        ctrl_c.imm         = zext16(imm16);
      end
      OP_ORI: begin
        ctrl_c.alu_op      = ALU_OR;
        ctrl_c.alu_src_imm = 1'b1;
        ctrl_c.reg_wr_en   = 1'b1;
        ctrl_c.rd          = rt_f;
        ctrl_c.imm         = zext16(imm16);
      end
      OP_LW: begin
        ctrl_c.alu_op      = ALU_ADD;
        ctrl_c.alu_src_imm = 1'b1;
        ctrl_c.reg_wr_en   = 1'b1;
        ctrl_c.mem_rd      = 1'b1;
        ctrl_c.rd          = rt_f;
        ctrl_c.imm         = sext16(imm16);
      end
      OP_SW: begin
        ctrl_c.alu_op      = ALU_ADD;
        ctrl_c.alu_src_imm = 1'b1;
        ctrl_c.mem_wr      = 1'b1;
        ctrl_c.uses_rt     = 1'b1;
        ctrl_c.imm         = sext16(imm16);
      end
      OP_BEQ: begin
        ctrl_c.alu_op  = ALU_SUB;
        ctrl_c.branch  = 1'b1;
        ctrl_c.uses_rt = 1'b1;
        ctrl_c.imm     = sext16(imm16);
      end
      default: ctrl_c.illegal = 1'b1;
    endcase
    // $0 is hardwired, so writes to it are suppressed here
    if (ctrl_c.rd == '0) ctrl_c.reg_wr_en = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, register_file read
// addressing, load-use stall, flush and the ID/EX pipeline register.
// Optional build macro DECODE_WB_BYPASS_EN forwards same-cycle write-back
// data onto the rs/rt operands.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned PC_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [31:0]         if_instr,
  input  logic [PC_W-1:0]     if_pc,
  output logic                if_ready,
  input  logic                flush,
  output logic [4:0]          r_reg1,
  output logic [4:0]          r_reg2,
  input  logic [31:0]         r1_data,
  input  logic [31:0]         r2_data,
  input  logic                wb_wr_en,
  input  logic [4:0]          wb_reg,
  input  logic [31:0]         wb_data,
  output logic                ex_valid,
  output logic [PC_W-1:0]     ex_pc,
  output logic [31:0]         ex_rs_data,
  output logic [31:0]         ex_rt_data,
  output logic [31:0]         ex_imm,
  output logic [4:0]          ex_rd,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src_imm,
  output logic                ex_reg_wr_en,
  output logic                ex_mem_rd,
  output logic                ex_mem_wr,
  output logic                ex_branch,
  output logic                ex_illegal
);

  // IF/ID register
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q,    id_pc_d;

  // ID/EX register
  logic                ex_valid_q,       ex_valid_d;
  logic [PC_W-1:0]     ex_pc_q,          ex_pc_d;
  logic [XLEN-1:0]     ex_rs_data_q,     ex_rs_data_d;
  logic [XLEN-1:0]     ex_rt_data_q,     ex_rt_data_d;
  logic [XLEN-1:0]     ex_imm_q,         ex_imm_d;
  logic [REG_W-1:0]    ex_rd_q,          ex_rd_d;
  logic [ALU_OP_W-1:0] ex_alu_op_q,      ex_alu_op_d;
  logic                ex_alu_src_imm_q, ex_alu_src_imm_d;
  logic                ex_reg_wr_en_q,   ex_reg_wr_en_d;
  logic                ex_mem_rd_q,      ex_mem_rd_d;
  logic                ex_mem_wr_q,      ex_mem_wr_d;
  logic                ex_branch_q,      ex_branch_d;
  logic                ex_illegal_q,     ex_illegal_d;

  ctrl_t            ctrl_c;
  logic [REG_W-1:0] rs_c;
  logic [REG_W-1:0] rt_c;
  logic [XLEN-1:0]  rs_val_c;
  logic [XLEN-1:0]  rt_val_c;
  logic             stall_c;

  decode_ctrl u_decode_ctrl (
    .instr  (id_instr_q),
    .ctrl_c (ctrl_c)
  );

  assign rs_c     = id_instr_q[25:21];
  assign rt_c     = id_instr_q[20:16];
  assign r_reg1   = rs_c;
  assign r_reg2   = rt_c;
  assign if_ready = !flush && (!id_valid_q || !stall_c);

  // Load-use hazard: the load in EX writes a register this instruction reads
  always_comb begin
    stall_c = 1'b0;
    if (id_valid_q && ex_valid_q && ex_mem_rd_q && (ex_rd_q != '0)) begin
      stall_c = (ex_rd_q == rs_c) || (ctrl_c.uses_rt && (ex_rd_q == rt_c));
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // Operand select with forwarding of a write-back not yet visible on the read port
  always_comb begin
    rs_val_c = r1_data;
    rt_val_c = r2_data;
    if (wb_wr_en && (wb_reg != '0) && (wb_reg == rs_c)) rs_val_c = wb_data;
    if (wb_wr_en && (wb_reg != '0) && (wb_reg == rt_c)) rt_val_c = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wr_en, wb_reg, wb_data};

  // Operands straight from the register_file read ports
  always_comb begin
    rs_val_c = r1_data;
    rt_val_c = r2_data;
  end
`endif

  // IF/ID next state: flush kills, accept loads, advance without refill empties
  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (if_valid && if_ready) begin
      id_valid_d = 1'b1;
      id_instr_d = if_instr;
      id_pc_d    = if_pc;
    end else if (id_valid_q && !stall_c) begin
      id_valid_d = 1'b0;
    end
  end

  // ID/EX next state: decoded instruction on advance, otherwise a bubble
  always_comb begin
    ex_valid_d       = 1'b0;
    ex_pc_d          = '0;
    ex_rs_data_d     = '0;
    ex_rt_data_d     = '0;
    ex_imm_d         = '0;
    ex_rd_d          = '0;
    ex_alu_op_d      = '0;
    ex_alu_src_imm_d = 1'b0;
    ex_reg_wr_en_d   = 1'b0;
    ex_mem_rd_d      = 1'b0;
    ex_mem_wr_d      = 1'b0;
    ex_branch_d      = 1'b0;
    ex_illegal_d     = 1'b0;
    if (!flush && id_valid_q && !stall_c) begin
      if (ctrl_c.illegal) begin
        ex_illegal_d = 1'b1;
      end else begin
        ex_valid_d       = 1'b1;
        ex_pc_d          = id_pc_q;
        ex_rs_data_d     = rs_val_c;
        ex_rt_data_d     = rt_val_c;
        ex_imm_d         = ctrl_c.imm;
        ex_rd_d          = ctrl_c.rd;
        ex_alu_op_d      = ALU_OP_W'(ctrl_c.alu_op);
        ex_alu_src_imm_d = ctrl_c.alu_src_imm;
        ex_reg_wr_en_d   = ctrl_c.reg_wr_en;
        ex_mem_rd_d      = ctrl_c.mem_rd;
        ex_mem_wr_d      = ctrl_c.mem_wr;
        ex_branch_d      = ctrl_c.branch;
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q       <= 1'b0;
      id_instr_q       <= '0;
      id_pc_q          <= '0;
      ex_valid_q       <= 1'b0;
      ex_pc_q          <= '0;
      ex_rs_data_q     <= '0;
      ex_rt_data_q     <= '0;
      ex_imm_q         <= '0;
      ex_rd_q          <= '0;
      ex_alu_op_q      <= '0;
      ex_alu_src_imm_q <= 1'b0;
      ex_reg_wr_en_q   <= 1'b0;
      ex_mem_rd_q      <= 1'b0;
      ex_mem_wr_q      <= 1'b0;
      ex_branch_q      <= 1'b0;
      ex_illegal_q     <= 1'b0;
    end else begin
      id_valid_q       <= id_valid_d;
      id_instr_q       <= id_instr_d;
      id_pc_q          <= id_pc_d;
      ex_valid_q       <= ex_valid_d;
      ex_pc_q          <= ex_pc_d;
      ex_rs_data_q     <= ex_rs_data_d;
      ex_rt_data_q     <= ex_rt_data_d;
      ex_imm_q         <= ex_imm_d;
      ex_rd_q          <= ex_rd_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_alu_src_imm_q <= ex_alu_src_imm_d;
      ex_reg_wr_en_q   <= ex_reg_wr_en_d;
      ex_mem_rd_q      <= ex_mem_rd_d;
      ex_mem_wr_q      <= ex_mem_wr_d;
      ex_branch_q      <= ex_branch_d;
      ex_illegal_q     <= ex_illegal_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_pc_q;
  assign ex_rs_data     = ex_rs_data_q;
  assign ex_rt_data     = ex_rt_data_q;
  assign ex_imm         = ex_imm_q;
  assign ex_rd          = ex_rd_q;
  assign ex_alu_op      = ex_alu_op_q;
  assign ex_alu_src_imm = ex_alu_src_imm_q;
  assign ex_reg_wr_en   = ex_reg_wr_en_q;
  assign ex_mem_rd      = ex_mem_rd_q;
  assign ex_mem_wr      = ex_mem_wr_q;
  assign ex_branch      = ex_branch_q;
  assign ex_illegal     = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases followed by random instruction
// streams, checked against a mnemonic-level reference model.
module tb_decode_stage;
  import mips_pkg::*;

  localparam int unsigned PC_W_TB  = 32;
  localparam int unsigned ALU_OP_T = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                if_valid;
  logic [31:0]         if_instr;
  logic [PC_W_TB-1:0]  if_pc;
  logic                if_ready;
  logic                flush;
  logic [4:0]          r_reg1, r_reg2;
  logic [31:0]         r1_data, r2_data;
  logic                wb_wr_en;
  logic [4:0]          wb_reg;
  logic [31:0]         wb_data;
  logic                ex_valid;
  logic [PC_W_TB-1:0]  ex_pc;
  logic [31:0]         ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]          ex_rd;
  logic [ALU_OP_T-1:0] ex_alu_op;
  logic                ex_alu_src_imm, ex_reg_wr_en, ex_mem_rd, ex_mem_wr;
  logic                ex_branch, ex_illegal;

  logic [31:0] regs [32];
  assign r1_data = regs[r_reg1];
  assign r2_data = regs[r_reg2];

  always #5 clk = ~clk;

  decode_stage #(.ALU_OP_W(ALU_OP_T), .PC_W(PC_W_TB)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .flush(flush),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .r1_data(r1_data), .r2_data(r2_data),
    .wb_wr_en(wb_wr_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_reg_wr_en(ex_reg_wr_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        src_imm, wr_en, mem_rd, mem_wr, branch, illegal;
  } ex_m_t;

  int    n_chk = 0;
  int    n_err = 0;
  logic  rand_wb = 1'b0;
  logic  obs_ready;
  logic        m_id_v;
  logic [31:0] m_id_instr, m_id_pc;
  ex_m_t       m_ex;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string mnem(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return "add";
        6'h22: return "sub";
        6'h23: return "subu";
        6'h24: return "and";
        6'h25: return "or";
        6'h2A: return "slt";
        default: return "ill";
      endcase
    end
    case (op)
      6'h08: return "addi";
      6'h0C: return "andi";
      6'h0D: return "ori";
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      default: return "ill";
    endcase
  endfunction

  function automatic bit is_rtype(input string m);
    return m == "add" || m == "sub" || m == "subu" || m == "and" || m == "or" || m == "slt";
  endfunction

  function automatic bit reads_rt(input string m);
    return is_rtype(m) || m == "sw" || m == "beq";
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_wr_en && wb_reg != 5'd0 && wb_reg == r) return wb_data;
`endif
    return regs[r];
  endfunction

  function automatic ex_m_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    ex_m_t       e;
    string       m;
    logic [31:0] s, z;
    m = mnem(ins);
    s = {{16{ins[15]}}, ins[15:0]};
    z = {16'h0000, ins[15:0]};
    e = '{default: '0};
    if (m == "ill") begin
      e.illegal = 1'b1;
      return e;
    end
    e.valid   = 1'b1;
    e.pc      = pc;
    e.rs_data = opnd(ins[25:21]);
    e.rt_data = opnd(ins[20:16]);
    if (is_rtype(m)) begin
      e.rd    = ins[15:11];
      e.wr_en = 1'b1;
      if (m == "add")       e.alu_op = ALU_ADD;
      else if (m == "sub")  e.alu_op = ALU_SUB;
      else if (m == "subu") e.alu_op = ALU_SUBU;
      else if (m == "and")  e.alu_op = ALU_AND;
      else if (m == "or")   e.alu_op = ALU_OR;
      else                  e.alu_op = ALU_SLT;
    end else if (m == "addi") begin
      e.rd = ins[20:16]; e.wr_en = 1'b1; e.src_imm = 1'b1; e.imm = s; e.alu_op = ALU_ADD;
    end else if (m == "andi") begin
      e.rd = ins[20:16]; e.wr_en = 1'b1; e.src_imm = 1'b1; e.imm = z; e.alu_op = ALU_AND;
    end else if (m == "ori") begin
      e.rd = ins[20:16]; e.wr_en = 1'b1; e.src_imm = 1'b1; e.imm = z; e.alu_op = ALU_OR;
    end else if (m == "lw") begin
      e.rd = ins[20:16]; e.wr_en = 1'b1; e.src_imm = 1'b1; e.imm = s; e.alu_op = ALU_ADD;
      e.mem_rd = 1'b1;
    end else if (m == "sw") begin
      e.src_imm = 1'b1; e.imm = s; e.alu_op = ALU_ADD; e.mem_wr = 1'b1;
    end else begin
      e.imm = s; e.alu_op = ALU_SUB; e.branch = 1'b1;
    end
    if (e.rd == 5'd0) e.wr_en = 1'b0;
    return e;
  endfunction

  task automatic check_ex();
    check_eq("ex_valid",       32'(ex_valid),       32'(m_ex.valid));
    check_eq("ex_pc",          ex_pc,               m_ex.pc);
    check_eq("ex_rs_data",     ex_rs_data,          m_ex.rs_data);
    check_eq("ex_rt_data",     ex_rt_data,          m_ex.rt_data);
    check_eq("ex_imm",         ex_imm,              m_ex.imm);
    check_eq("ex_rd",          32'(ex_rd),          32'(m_ex.rd));
    check_eq("ex_alu_op",      32'(ex_alu_op),      32'(m_ex.alu_op));
    check_eq("ex_alu_src_imm", 32'(ex_alu_src_imm), 32'(m_ex.src_imm));
    check_eq("ex_reg_wr_en",   32'(ex_reg_wr_en),   32'(m_ex.wr_en));
    check_eq("ex_mem_rd",      32'(ex_mem_rd),      32'(m_ex.mem_rd));
    check_eq("ex_mem_wr",      32'(ex_mem_wr),      32'(m_ex.mem_wr));
    check_eq("ex_branch",      32'(ex_branch),      32'(m_ex.branch));
    check_eq("ex_illegal",     32'(ex_illegal),     32'(m_ex.illegal));
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model,
  // then check the registered outputs at the following negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl);
    logic        stall_m, ready_m;
    logic [4:0]  rs, rt;
    string       m;
    ex_m_t       ex_n;
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    flush    = fl;
    if (rand_wb) begin
      wb_wr_en = 1'($urandom_range(0, 1));
      wb_reg   = 5'($urandom_range(0, 4));
      wb_data  = $urandom;
    end
    #1;
    rs = m_id_instr[25:21];
    rt = m_id_instr[20:16];
    m  = mnem(m_id_instr);
    stall_m = m_id_v && m_ex.valid && m_ex.mem_rd && m_ex.rd != 5'd0 &&
              (m_ex.rd == rs || (reads_rt(m) && m_ex.rd == rt));
    ready_m = !fl && (!m_id_v || !stall_m);
    obs_ready = if_ready;
    check_eq("if_ready", 32'(if_ready), 32'(ready_m));
    check_eq("r_reg1",   32'(r_reg1),   32'(rs));
    check_eq("r_reg2",   32'(r_reg2),   32'(rt));
    ex_n = '{default: '0};
    if (!fl && m_id_v && !stall_m) ex_n = model_decode(m_id_instr, m_id_pc);
    @(posedge clk);
    m_ex = ex_n;
    if (fl) m_id_v = 1'b0;
    else if (v && ready_m) begin
      m_id_v = 1'b1; m_id_instr = ins; m_id_pc = pc;
    end else if (m_id_v && !stall_m) m_id_v = 1'b0;
    @(negedge clk);
    check_ex();
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [4:0]  a, b, c;
    logic [15:0] im;
    k  = $urandom_range(0, 13);
    a  = 5'($urandom_range(0, 4));
    b  = 5'($urandom_range(0, 4));
    c  = 5'($urandom_range(0, 4));
    im = 16'($urandom);
    case (k)
      0:  return {6'h00, a, b, c, 5'd0, 6'h20};
      1:  return {6'h00, a, b, c, 5'd0, 6'h22};
      2:  return {6'h00, a, b, c, 5'd0, 6'h23};
      3:  return {6'h00, a, b, c, 5'd0, 6'h24};
      4:  return {6'h00, a, b, c, 5'd0, 6'h25};
      5:  return {6'h00, a, b, c, 5'd0, 6'h2A};
      6:  return {6'h08, a, b, im};
      7:  return {6'h0C, a, b, im};
      8:  return {6'h0D, a, b, im};
      9:  return {6'h23, a, b, im};
      10: return {6'h2B, a, b, im};
      11: return {6'h04, a, b, im};
      12: return {6'h20, a, b, im};
      default: return {6'h00, a, b, c, 5'd0, 6'h3F};
    endcase
  endfunction

  localparam logic [31:0] I_ADD   = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] I_LW    = 32'h8C220004; // lw  $2,4($1)
  localparam logic [31:0] I_ADD2  = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] I_ADDI  = 32'h2005FFFF; // addi $5,$0,-1
  localparam logic [31:0] I_ORI   = 32'h3405FFFF; // ori  $5,$0,0xFFFF
  localparam logic [31:0] I_ILL   = 32'h80221820; // opcode 0x20
  localparam logic [31:0] I_ADDR0 = 32'h00220020; // add $0,$1,$2

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0; regs[1] = 32'd5; regs[2] = 32'd7; regs[4] = 32'd9;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    wb_wr_en = 1'b0; wb_reg = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ex_valid",   32'(ex_valid),   32'd0);
    check_eq("rst_ex_alu_op",  32'(ex_alu_op),  32'd0);
    check_eq("rst_ex_imm",     ex_imm,          32'd0);
    check_eq("rst_ex_illegal", 32'(ex_illegal), 32'd0);
    check_eq("rst_if_ready",   32'(if_ready),   32'd1);
    rst = 1'b0;
    m_id_v = 1'b0; m_id_instr = '0; m_id_pc = '0; m_ex = '{default: '0};

    // add $3,$1,$2 reaches EX two clocks after acceptance
    step(1'b1, I_ADD, 32'h1000, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("add_valid", 32'(ex_valid),     32'd1);
    check_eq("add_rs",    ex_rs_data,        32'd5);
    check_eq("add_rt",    ex_rt_data,        32'd7);
    check_eq("add_rd",    32'(ex_rd),        32'd3);
    check_eq("add_op",    32'(ex_alu_op),    32'(ALU_ADD));
    check_eq("add_wr",    32'(ex_reg_wr_en), 32'd1);

    // load-use: one bubble, one cycle of back-pressure
    step(1'b1, I_LW,   32'h1004, 1'b0);
    step(1'b1, I_ADD2, 32'h1008, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("lu_ready", 32'(obs_ready), 32'd0);
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("lu_issue", 32'(ex_valid), 32'd1);
    check_eq("lu_rd",    32'(ex_rd),    32'd3);

    // immediate extension
    step(1'b1, I_ADDI, 32'h100C, 1'b0);
    step(1'b1, I_ORI,  32'h1010, 1'b0);
    check_eq("addi_imm", ex_imm, 32'hFFFFFFFF);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("ori_imm", ex_imm, 32'h0000FFFF);

    // flush during a stall
    step(1'b1, I_LW,   32'h1014, 1'b0);
    step(1'b1, I_ADD2, 32'h1018, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check_eq("fl_valid", 32'(ex_valid), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("fl_ready", 32'(obs_ready), 32'd1);
    check_eq("fl_drop",  32'(ex_valid),  32'd0);

    // illegal opcode pulses once; add to $0 does not write
    step(1'b1, I_ILL, 32'h101C, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("ill_pulse", 32'(ex_illegal), 32'd1);
    check_eq("ill_valid", 32'(ex_valid),   32'd0);
    step(1'b1, I_ADDR0, 32'h1020, 1'b0);
    check_eq("ill_end", 32'(ex_illegal), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("rd0_wr", 32'(ex_reg_wr_en), 32'd0);

    // write-back on rs while the add sits in decode
    step(1'b1, I_ADD, 32'h1024, 1'b0);
    wb_wr_en = 1'b1; wb_reg = 5'd1; wb_data = 32'hA5;
    step(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef DECODE_WB_BYPASS_EN
    check_eq("byp_rs", ex_rs_data, 32'hA5);
`else
    check_eq("byp_rs", ex_rs_data, 32'd5);
`endif
    wb_wr_en = 1'b0;

    // random streams with hazards, flushes and write-back traffic
    rand_wb = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
           1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
